// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: byte/half/word load-store controller for a word-wide memory.
// Sub-word stores are done as read-modify-write. Loads are lane-extracted
// and then sign- or zero-extended.
//
// Ports:
//   Clk, Reset        clock and synchronous active-high reset
//   Start             request strobe; it is sampled only in IDLE
//   Write             1 = store, 0 = load
//   Size              00 word, 01 half, 10 byte, 11 word
//   Unsigned          for loads, 1 = zero-extend, 0 = sign-extend
//   Addr, WrData      byte address and right-aligned store data
//   MemDataOut        word read back from memory, valid READ_WAIT cycles after MemAddr
//   MemAddr           word-aligned address, held from cycle 1 until the next accepted Start
//   MemWr, MemDataIn  one-cycle write strobe and the registered write word
//   RdData            extended load result, held until the next completed load
//   Busy, Done        busy flag and one-cycle completion pulse
//   AddrErr           misalignment flag, held until the next accepted Start
module mem_rmw_ctrl #(
  parameter int READ_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  input  logic [31:0] MemDataOut,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemDataIn,
  output logic [31:0] RdData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, CAPTURE, WRITE, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem_addr_q, mem_din_q, rd_data_q;
  logic [15:0] wdata_q;
  logic [1:0]  lane_q;
  logic        byte_q, half_q, write_q, uns_q, addr_err_q;
  logic [3:0]  cnt_q;

  // Decode of the incoming request. Size 11 falls through to word.
  logic is_byte, is_half, is_word, misaligned, accept;
  assign is_byte    = (Size == 2'b10);
  assign is_half    = (Size == 2'b01);
  assign is_word    = !is_byte && !is_half;
  assign misaligned = (is_half && Addr[0]) || (is_word && (Addr[1:0] != 2'b00));
  assign accept     = (state_q == IDLE) && Start;

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (Start) begin
        if (misaligned)           state_d = DONE;
        else if (Write && is_word) state_d = WRITE;
        else                      state_d = RD_WAIT;
      end
      RD_WAIT: if (cnt_q == 4'(READ_WAIT)) state_d = CAPTURE;
      CAPTURE: state_d = write_q ? WRITE : DONE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Lane extraction for loads and lane merge for stores, both working on
  // the word read from memory.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_d, merged_d;
  assign byte_sel = MemDataOut[{lane_q, 3'b000} +: 8];
  assign half_sel = MemDataOut[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    load_d = MemDataOut;
    if (byte_q)      load_d = {{24{!uns_q && byte_sel[7]}}, byte_sel};
    else if (half_q) load_d = {{16{!uns_q && half_sel[15]}}, half_sel};
  end

  always_comb begin
    merged_d = MemDataOut;
    if (half_q) merged_d[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    else        merged_d[{lane_q, 3'b000} +: 8]      = wdata_q[7:0];
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rd_data_q  <= '0;
      wdata_q    <= '0;
      lane_q     <= '0;
      byte_q     <= 1'b0;
      half_q     <= 1'b0;
      write_q    <= 1'b0;
      uns_q      <= 1'b0;
      addr_err_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (accept) begin
        mem_addr_q <= {Addr[31:2], 2'b00};
        lane_q     <= Addr[1:0];
        wdata_q    <= WrData[15:0];
        byte_q     <= is_byte;
        half_q     <= is_half;
        write_q    <= Write;
        uns_q      <= Unsigned;
        addr_err_q <= misaligned;
        cnt_q      <= 4'd1;
        // A word store writes straight away, so load the write word now.
        if (Write && is_word && !misaligned) mem_din_q <= WrData;
      end
      if (state_q == RD_WAIT) cnt_q <= cnt_q + 4'd1;
      if (state_q == CAPTURE) begin
        if (write_q) mem_din_q <= merged_d;
        else         rd_data_q <= load_d;
      end
    end
  end

  assign MemAddr   = mem_addr_q;
  assign MemDataIn = mem_din_q;
  assign RdData    = rd_data_q;
  assign AddrErr   = addr_err_q;
  assign MemWr     = (state_q == WRITE);
  assign Done      = (state_q == DONE);
  assign Busy      = (state_q != IDLE);

endmodule

// File: doc/mem_rmw_ctrl.md
MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Parameters
REQ-001 The block SHALL have the parameter READ_WAIT, default 2, which sets the number of cycles between MemAddr becoming valid and MemDataOut being valid (legal range 1..15).

Interface
REQ-002 The block SHALL have the port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port Reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have the port Start, input, 1 bit: request strobe, sampled only in IDLE.
REQ-005 The block SHALL have the port Write, input, 1 bit: 1 = store, 0 = load.
REQ-006 The block SHALL have the port Size, input, 2 bits: 00 = word, 01 = half, 10 = byte; 11 is treated as word.
REQ-007 The block SHALL have the port Unsigned, input, 1 bit: for loads, 1 = zero-extend, 0 = sign-extend.
REQ-008 The block SHALL have the port Addr, input, 32 bits: byte address of the access.
REQ-009 The block SHALL have the port WrData, input, 32 bits: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 The block SHALL have the port MemDataOut, input, 32 bits: word read from the word-wide memory.
REQ-011 The block SHALL have the port MemAddr, output, 32 bits: word address to memory, {Addr[31:2],2'b00}.
REQ-012 The block SHALL have the port MemWr, output, 1 bit: memory write enable.
REQ-013 The block SHALL have the port MemDataIn, output, 32 bits: registered word to be written to memory.
REQ-014 The block SHALL have the port RdData, output, 32 bits: extended load result.
REQ-015 The block SHALL have the ports Busy, Done and AddrErr, outputs, 1 bit each: busy flag, 1-cycle completion pulse, and misalignment flag.

Function
REQ-016 The FSM states SHALL be IDLE, RD_WAIT, CAPTURE, WRITE and DONE.
REQ-017 Start=1 in IDLE (cycle 0) SHALL latch Addr, WrData, Size, Write and Unsigned, and drive MemAddr from cycle 1 until the next accepted Start.
REQ-018 Start in any state other than IDLE, including DONE, SHALL be ignored, with no effect on the operation in progress.
REQ-019 Busy SHALL be 1 in every state except IDLE.
REQ-020 A misaligned access (half with Addr[0]=1, or word with Addr[1:0]!=0) SHALL go IDLE->DONE with AddrErr=1 and Done=1 in cycle 1; MemWr SHALL never assert, and RdData SHALL be unchanged.
REQ-021 A word store SHALL go IDLE->WRITE->DONE, with MemWr=1 and MemDataIn=WrData in cycle 1 only and Done=1 in cycle 2.
REQ-022 A load SHALL go IDLE->RD_WAIT (cycles 1..READ_WAIT)->CAPTURE (cycle READ_WAIT+1, MemDataOut sampled at its end)->DONE (cycle READ_WAIT+2, Done=1, RdData valid).
REQ-023 A byte or half store SHALL perform a read-modify-write: RD_WAIT->CAPTURE (merged word registered into MemDataIn)->WRITE (cycle READ_WAIT+2, MemWr=1)->DONE (cycle READ_WAIT+3).
REQ-024 Byte lanes SHALL be little-endian: byte k=Addr[1:0] occupies bits [8k+7:8k]; half h=Addr[1] occupies bits [16h+15:16h].
REQ-025 The merge SHALL replace only the addressed lane with WrData[7:0] or WrData[15:0] and preserve all other bits of the word read.
REQ-026 Loads SHALL extract the addressed lane, then zero-extend if Unsigned=1 or replicate the lane MSB if Unsigned=0; word loads SHALL pass the word through unchanged.
REQ-027 MemWr SHALL be 1 only in WRITE and SHALL be high for exactly one cycle per store.
REQ-028 MemDataIn SHALL be stable throughout WRITE.
REQ-029 RdData SHALL hold its value until the next completed load.
REQ-030 AddrErr SHALL hold its value until the next accepted Start, which clears it unless that access is also misaligned.
REQ-031 Done SHALL be 1 only in DONE, and DONE SHALL always return to IDLE on the next cycle.
REQ-032 Any address, including 0xFFFFFFFC, SHALL be legal, with no wrap-around or bounds checking.

Reset
REQ-033 Reset=1 at a rising edge SHALL force the FSM to IDLE and set Busy, Done, MemWr and AddrErr to 0 and MemAddr, MemDataIn and RdData to 0x00000000.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no MemWr pulse issued at or after that edge.
REQ-035 Reset SHALL take priority over Start in the same cycle.

Verification (READ_WAIT=2)
REQ-036 The bench SHALL cover a word store: SW 0xDEADBEEF at Addr 0x10 -> MemAddr=0x10, MemWr=1 in cycle 1 only with MemDataIn=0xDEADBEEF, Done in cycle 2.
REQ-037 The bench SHALL cover byte loads: LB at 0x13 with memory word 0x80FF7F01 -> Done in cycle 4 with RdData=0xFFFFFF80; the same access as LBU -> RdData=0x00000080.
REQ-038 The bench SHALL cover a byte store: SB WrData=0x000000AB at 0x21 with memory word 0x11223344 -> MemWr in cycle 4 with MemDataIn=0x1122AB44, Done in cycle 5.
REQ-039 The bench SHALL cover a misaligned store: SH at 0x23 -> Done=1 and AddrErr=1 in cycle 1, MemWr stays 0, Busy=0 in cycle 2.
REQ-040 The bench SHALL cover reset mid-operation: Reset in cycle 2 of an SB -> Busy=0 from cycle 3, MemWr never asserts, all outputs zero.
REQ-041 The bench SHALL cover Start while busy: a second Start in cycle 2 of an LW -> ignored, only one Done (cycle 4), and the latched Addr is unchanged.
